// File: rtl/color_code_gen_pkg.sv
// Shared types and constants for the colour-code generator: palette,
// reset indices and FSM state encoding.
// Optional feature macro: AUTO_CYCLE_EN (see color_code_gen.sv).
package color_code_pkg;

  // Default palette index width; the palette table below holds 2**PAL_W_DEF entries.
  localparam int PAL_W_DEF = 3;

  // Reset palette indices and the colour code they produce.
  localparam logic [PAL_W_DEF-1:0] IDX_L_RST = 3'd1;
  localparam logic [PAL_W_DEF-1:0] IDX_R_RST = 3'd3;
  localparam logic [23:0]          CODE_RST  = 24'hF00_00F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } cc_state_t;

  // 12-bit RGB palette entry for a given index.
  function automatic logic [11:0] pal_lookup(input logic [PAL_W_DEF-1:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'h000;
      3'd1:    rgb = 12'hF00;
      3'd2:    rgb = 12'h0F0;
      3'd3:    rgb = 12'h00F;
      3'd4:    rgb = 12'hFF0;
      3'd5:    rgb = 12'h0FF;
      3'd6:    rgb = 12'hF0F;
      3'd7:    rgb = 12'hFFF;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/color_code_gen_if.sv
// Bus between the colour-code generator and its environment: raw buttons,
// vsync from the VGA stage, and the committed code / status outputs.
interface color_code_gen_if;
  logic        btn_next;
  logic        btn_slot;
  logic        vsync_in;
  logic [23:0] code;
  logic        slot_sel;
  logic        pending;

  // Environment side: drives buttons and vsync, observes the code.
  modport master (
    output btn_next, btn_slot, vsync_in,
    input  code, slot_sel, pending
  );

  // Generator side.
  modport slave (
    input  btn_next, btn_slot, vsync_in,
    output code, slot_sel, pending
  );
endinterface

// File: rtl/color_code_gen_btn_sync_edge.sv
// Multi-flop synchronizer for an asynchronous push-button followed by a
// rising-edge detector: a held level yields exactly one single-cycle pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level through the synchronizer and remember the last synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both terms come straight from flops, so the pulse is glitch-free in the clk domain.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/color_code_gen.sv
// Colour-code generator: button-edited left/right palette indices live in
// shadow registers and are committed to the 24-bit code only at the end of
// a vsync pulse, so a frame never shows a mix of old and new colours.
// Optional feature macro: AUTO_CYCLE_EN -- advances both indices every
// AUTO_FRAMES frames when defined.
module color_code_gen
  import color_code_pkg::*;
#(
  parameter int PAL_W       = PAL_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst,
  color_code_gen_if.slave  bus
);

  logic             next_pulse;
  logic             slot_pulse;
  logic             frame_edge;
  logic             auto_adv;
  logic             edit;

  logic             vs_q;
  logic             vs_prev_q;
  logic [PAL_W-1:0] idx_l_q, idx_l_d;
  logic [PAL_W-1:0] idx_r_q, idx_r_d;
  logic             slot_q, slot_d;
  logic [23:0]      code_q, code_d;
  logic             pending_q, pending_d;
  cc_state_t        state_q, state_d;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_next),
    .pulse   (next_pulse)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_slot_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_slot),
    .pulse   (slot_pulse)
  );

  // Sample vsync twice so the end of the sync pulse (0 -> 1) is seen as a one-cycle frame_edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_q      <= bus.vsync_in;
      vs_prev_q <= vs_q;
    end
  end

  assign frame_edge = vs_q & ~vs_prev_q;

`ifdef AUTO_CYCLE_EN
  localparam int CNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign auto_adv = frame_edge && (frame_cnt_q == CNT_W'(AUTO_FRAMES - 1));

  // Frame counter: any button activity restarts the idle period; wraps at the advance.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (next_pulse || slot_pulse || auto_adv) begin
      frame_cnt_d = '0;
    end else if (frame_edge) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  // Anything that changes a shadow index must eventually be committed.
  assign edit = next_pulse | auto_adv;

  // Shadow index / slot update, FSM next state and commit of the code.
  always_comb begin
    // Increment uses the pre-toggle slot; a simultaneous slot press toggles afterwards.
    idx_l_d = idx_l_q + PAL_W'(next_pulse & ~slot_q) + PAL_W'(auto_adv);
    idx_r_d = idx_r_q + PAL_W'(next_pulse &  slot_q) + PAL_W'(auto_adv);
    slot_d  = slot_q ^ slot_pulse;
    state_d = state_q;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (edit) state_d = S_PENDING;
        else      state_d = S_IDLE;
      end
      S_PENDING: begin
        if (frame_edge) state_d = S_COMMIT;
        else            state_d = S_PENDING;
      end
      S_COMMIT: begin
        // Shadow already holds any edit from the frame_edge cycle; only an
        // edit landing now would be missed by this commit.
        code_d = {pal_lookup(idx_l_q), pal_lookup(idx_r_q)};
        if (edit) state_d = S_PENDING;
        else      state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = (state_d != S_IDLE);
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_l_q   <= IDX_L_RST;
      idx_r_q   <= IDX_R_RST;
      slot_q    <= 1'b0;
      code_q    <= CODE_RST;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_l_q   <= idx_l_d;
      idx_r_q   <= idx_r_d;
      slot_q    <= slot_d;
      code_q    <= code_d;
      pending_q <= pending_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.slot_sel = slot_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_color_code_gen.sv
// Directed self-checking bench for color_code_gen. With AUTO_CYCLE_EN defined
// it checks the automatic advance, otherwise that the code stays static.
module tb_color_code_gen;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  color_code_gen_if bus ();

  color_code_gen #(
    .PAL_W       (3),
    .SYNC_STAGES (2),
    .AUTO_FRAMES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic nxt, input logic slt);
    bus.btn_next = nxt;
    bus.btn_slot = slt;
    repeat (3) tick();
    bus.btn_next = 1'b0;
    bus.btn_slot = 1'b0;
    repeat (3) tick();
  endtask

  // Full vsync pulse, ending 2 clocks after the rising edge is sampled.
  task automatic frame();
    bus.vsync_in = 1'b0;
    tick();
    tick();
    bus.vsync_in = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic do_reset();
    bus.vsync_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_slot = 1'b0;
    bus.vsync_in = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_code",    bus.code, 24'hF00_00F);
    check("rst_slot",    {23'd0, bus.slot_sel}, 24'd0);
    check("rst_pending", {23'd0, bus.pending},  24'd0);
    tick();
    rst = 1'b0;
    tick();

    // Held next button: single increment of idx_l (1 -> 2), code unchanged.
    bus.btn_next = 1'b1;
    repeat (5) tick();
    bus.btn_next = 1'b0;
    tick();
    tick();
    check("t2_pending", {23'd0, bus.pending}, 24'd1);
    check("t2_code_hold", bus.code, 24'hF00_00F);
    check("t2_slot", {23'd0, bus.slot_sel}, 24'd0);
    bus.vsync_in = 1'b0;
    tick();
    tick();
    bus.vsync_in = 1'b1;
    tick();
    check("t2_lat_e0", bus.code, 24'hF00_00F);
    tick();
    check("t2_lat_e1", bus.code, 24'hF00_00F);
    tick();
    check("t2_lat_e2", bus.code, 24'h0F0_00F);
    check("t2_pending_clr", {23'd0, bus.pending}, 24'd0);

    // Reset mid-commit: no partial write, everything back to reset values.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("t1_pre_slot", {23'd0, bus.slot_sel}, 24'd1);
    bus.vsync_in = 1'b0;
    tick();
    tick();
    bus.vsync_in = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t1_code", bus.code, 24'hF00_00F);
    check("t1_slot", {23'd0, bus.slot_sel}, 24'd0);
    check("t1_pending", {23'd0, bus.pending}, 24'd0);
    tick();
    tick();
    check("t1_code_held", bus.code, 24'hF00_00F);
    rst = 1'b0;
    tick();

    // Right slot: 3 -> 4,5,6,7,0 with wrap.
    do_reset();
    press(1'b0, 1'b1);
    check("t3_slot", {23'd0, bus.slot_sel}, 24'd1);
    check("t3_no_pending", {23'd0, bus.pending}, 24'd0);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check("t3_pending", {23'd0, bus.pending}, 24'd1);
    check("t3_code_hold", bus.code, 24'hF00_00F);
    frame();
    check("t3_code", bus.code, 24'hF00_000);
    check("t3_pending_clr", {23'd0, bus.pending}, 24'd0);

    // Same-cycle next+slot: increments left (pre-toggle), then toggles.
    do_reset();
    press(1'b1, 1'b1);
    check("t4_slot", {23'd0, bus.slot_sel}, 24'd1);
    check("t4_pending", {23'd0, bus.pending}, 24'd1);
    // Next pulse coincides with frame_edge: idx_r 3 -> 4 joins the commit.
    bus.vsync_in = 1'b0;
    tick();
    tick();
    bus.btn_next = 1'b1;
    tick();
    bus.vsync_in = 1'b1;
    tick();
    tick();
    bus.btn_next = 1'b0;
    check("t4_edge_hold", bus.code, 24'hF00_00F);
    tick();
    check("t4_edge_commit", bus.code, 24'h0F0_FF0);
    check("t4_edge_pending", {23'd0, bus.pending}, 24'd0);

    // No frame_edge for 1000 cycles: code frozen while edits accumulate.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(1'b1, 1'b0);
      repeat (94) tick();
      check("t5_code_frozen", bus.code, 24'hF00_00F);
    end
    check("t5_pending", {23'd0, bus.pending}, 24'd1);
    frame();
    check("t5_commit", bus.code, 24'h00F_00F);

    // Automatic advance every 4 frames (or static code without the feature).
    do_reset();
`ifdef AUTO_CYCLE_EN
    repeat (4) frame();
    check("t6_auto_pending", {23'd0, bus.pending}, 24'd1);
    check("t6_auto_hold", bus.code, 24'hF00_00F);
    frame();
    check("t6_auto_code", bus.code, 24'h0F0_FF0);
    check("t6_auto_pending_clr", {23'd0, bus.pending}, 24'd0);
`else
    repeat (5) frame();
    check("t6_static_code", bus.code, 24'hF00_00F);
    check("t6_static_pending", {23'd0, bus.pending}, 24'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
